// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller and its benches.
package counter_seq_ctrl_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int PER_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/counter_seq_ctrl_dp.sv
// Up/down counter datapath with synchronous load and step enable.
module counter_dp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over stepping; stepping wraps modulo 2^WIDTH in either direction.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = dir ? (count_q - ONE) : (count_q + ONE);
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller: start/capture, run/pause, terminal detect, reload and period count.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             dir,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [PER_W-1:0] periods,
  output logic [1:0]       state
);

  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [PER_W-1:0] periods_q, periods_d;
  logic             dir_q, dir_d;
  logic             auto_q, auto_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] term_q, term_d;

  logic             dp_load;
  logic [WIDTH-1:0] dp_load_val;
  logic             dp_en;
  logic [WIDTH-1:0] count_w;

  counter_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (dp_load),
    .load_val (dp_load_val),
    .en       (dp_en),
    .dir      (dir_q),
    .count    (count_w)
  );

  // Next-state, capture and datapath control; clear overrides all state behaviour.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    periods_d   = periods_q;
    dir_d       = dir_q;
    auto_d      = auto_q;
    load_d      = load_q;
    term_d      = term_q;
    dp_load     = 1'b0;
    dp_load_val = load_q;
    dp_en       = 1'b0;

    if (clear) begin
      state_d     = ST_IDLE;
      periods_d   = '0;
      dp_load     = 1'b1;
      dp_load_val = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dir_d       = dir;
            auto_d      = auto_reload;
            load_d      = load_val;
            term_d      = term_val;
            periods_d   = '0;
            dp_load     = 1'b1;
            dp_load_val = load_val;
            state_d     = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (count_w == term_q) begin
            done_d = 1'b1;
            if (periods_q != PER_MAX) begin
              periods_d = periods_q + PER_ONE;
            end
            if (auto_q) begin
              dp_load     = 1'b1;
              dp_load_val = load_q;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            dp_en = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and capture registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      periods_q <= '0;
      dir_q     <= 1'b0;
      auto_q    <= 1'b0;
      load_q    <= '0;
      term_q    <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      periods_q <= periods_d;
      dir_q     <= dir_d;
      auto_q    <= auto_d;
      load_q    <= load_d;
      term_q    <= term_d;
    end
  end

  assign count   = count_w;
  assign done    = done_q;
  assign periods = periods_q;
  assign state   = state_q;
  assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed self-checking bench for counter_seq_ctrl.
module tb_counter_seq_ctrl;
  import counter_seq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic       dir = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] term_val = '0;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [3:0] periods;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] m_count;
  logic [3:0] m_per;
  logic       m_done;

  counter_seq_ctrl #(.WIDTH(4), .PER_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .clear       (clear),
    .dir         (dir),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .term_val    (term_val),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .periods     (periods),
    .state       (state)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic c, input logic d,
                               input logic ar, input logic [3:0] lv, input logic [3:0] tv);
    start       = s;
    pause       = p;
    clear       = c;
    dir         = d;
    auto_reload = ar;
    load_val    = lv;
    term_val    = tv;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_count, input logic [1:0] e_state,
                             input logic e_done, input logic [3:0] e_per, input logic e_busy);
    logic [11:0] got;
    logic [11:0] exp;
    got = {count, state, done, periods, busy};
    exp = {e_count, e_state, e_done, e_per, e_busy};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got count=%0d state=%0d done=%0d periods=%0d busy=%0d, expected count=%0d state=%0d done=%0d periods=%0d busy=%0d",
             tag, count, state, done, periods, busy, e_count, e_state, e_done, e_per, e_busy);
    end
  endtask

  initial begin
    // Reset for two cycles
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset", 4'd0, ST_IDLE, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("idle_after_reset", 4'd0, ST_IDLE, 1'b0, 4'd0, 1'b0);

    // Up count 2..5, single done, hold in DONE
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd5);
    tick();
    checkOutput("up_load", 4'd2, ST_RUN, 1'b0, 4'd0, 1'b1);
    start = 1'b0;
    tick();
    checkOutput("up_3", 4'd3, ST_RUN, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("up_4", 4'd4, ST_RUN, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("up_5", 4'd5, ST_RUN, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("up_done", 4'd5, ST_DONE, 1'b1, 4'd1, 1'b0);
    tick();
    checkOutput("up_hold", 4'd5, ST_DONE, 1'b0, 4'd1, 1'b0);

    // Restart from DONE: down count through the 0->15 wrap
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd14);
    tick();
    checkOutput("dn_load", 4'd1, ST_RUN, 1'b0, 4'd0, 1'b1);
    start = 1'b0;
    tick();
    checkOutput("dn_0", 4'd0, ST_RUN, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("dn_wrap15", 4'd15, ST_RUN, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("dn_14", 4'd14, ST_RUN, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("dn_done", 4'd14, ST_DONE, 1'b1, 4'd1, 1'b0);

    // Pause for three cycles at count 4
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
    tick();
    checkOutput("ps_load", 4'd0, ST_RUN, 1'b0, 4'd0, 1'b1);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("ps_run", 4'(i), ST_RUN, 1'b0, 4'd0, 1'b1);
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("ps_hold", 4'd4, ST_PAUSE, 1'b0, 4'd0, 1'b1);
    end
    pause = 1'b0;
    tick();
    checkOutput("ps_resume", 4'd4, ST_RUN, 1'b0, 4'd0, 1'b1);
    for (int i = 5; i <= 9; i++) begin
      tick();
      checkOutput("ps_run2", 4'(i), ST_RUN, 1'b0, 4'd0, 1'b1);
    end
    tick();
    checkOutput("ps_done", 4'd9, ST_DONE, 1'b1, 4'd1, 1'b0);

    // Auto-reload 3..5; start held with a different load_val while running is ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd5);
    tick();
    checkOutput("ar_load", 4'd3, ST_RUN, 1'b0, 4'd0, 1'b1);
    load_val = 4'd9;
    tick();
    checkOutput("ar_4_start_ign", 4'd4, ST_RUN, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("ar_5_start_ign", 4'd5, ST_RUN, 1'b0, 4'd0, 1'b1);
    start = 1'b0;
    tick();
    checkOutput("ar_reload1", 4'd3, ST_RUN, 1'b1, 4'd1, 1'b1);
    tick();
    checkOutput("ar_4b", 4'd4, ST_RUN, 1'b0, 4'd1, 1'b1);
    tick();
    checkOutput("ar_5b", 4'd5, ST_RUN, 1'b0, 4'd1, 1'b1);
    tick();
    checkOutput("ar_reload2", 4'd3, ST_RUN, 1'b1, 4'd2, 1'b1);
    m_count = 4'd3;
    m_per   = 4'd2;
    for (int i = 0; i < 45; i++) begin
      if (m_count == 4'd5) begin
        m_count = 4'd3;
        m_done  = 1'b1;
        if (m_per != 4'd15) m_per = m_per + 4'd1;
      end else begin
        m_count = m_count + 4'd1;
        m_done  = 1'b0;
      end
      tick();
      checkOutput("ar_loop", m_count, ST_RUN, m_done, m_per, 1'b1);
    end
    checkOutput("ar_saturated", m_count, ST_RUN, m_done, 4'd15, 1'b1);

    // Clear aborts the running auto-reload sequence
    clear = 1'b1;
    tick();
    checkOutput("clr_ar", 4'd0, ST_IDLE, 1'b0, 4'd0, 1'b0);
    clear = 1'b0;

    // Clear at count 7
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd12);
    tick();
    checkOutput("c7_load", 4'd0, ST_RUN, 1'b0, 4'd0, 1'b1);
    start = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    checkOutput("c7_at7", 4'd7, ST_RUN, 1'b0, 4'd0, 1'b1);
    clear = 1'b1;
    tick();
    checkOutput("c7_clear", 4'd0, ST_IDLE, 1'b0, 4'd0, 1'b0);
    clear = 1'b0;
    tick();
    checkOutput("c7_idle", 4'd0, ST_IDLE, 1'b0, 4'd0, 1'b0);

    // Asynchronous reset pulse between edges
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd12);
    tick();
    start = 1'b0;
    tick();
    checkOutput("ar_pre_rst", 4'd3, ST_RUN, 1'b0, 4'd0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 4'd0, ST_IDLE, 1'b0, 4'd0, 1'b0);
    #1;
    rst = 1'b0;
    tick();
    checkOutput("post_rst", 4'd0, ST_IDLE, 1'b0, 4'd0, 1'b0);

    // load == term without reload: done on the second edge
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd6);
    tick();
    checkOutput("eq_load", 4'd6, ST_RUN, 1'b0, 4'd0, 1'b1);
    start = 1'b0;
    tick();
    checkOutput("eq_done", 4'd6, ST_DONE, 1'b1, 4'd1, 1'b0);

    // load == term with reload: done every cycle
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd8);
    tick();
    checkOutput("eqar_load", 4'd8, ST_RUN, 1'b0, 4'd0, 1'b1);
    start = 1'b0;
    tick();
    checkOutput("eqar_1", 4'd8, ST_RUN, 1'b1, 4'd1, 1'b1);
    tick();
    checkOutput("eqar_2", 4'd8, ST_RUN, 1'b1, 4'd2, 1'b1);
    tick();
    checkOutput("eqar_3", 4'd8, ST_RUN, 1'b1, 4'd3, 1'b1);
    clear = 1'b1;
    tick();
    checkOutput("eqar_clear", 4'd0, ST_IDLE, 1'b0, 4'd0, 1'b0);
    clear = 1'b0;

    // Golden compare against a free-running 4-bit ripple counter
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15);
    tick();
    checkOutput("gold_load", 4'd0, ST_RUN, 1'b0, 4'd0, 1'b1);
    start   = 1'b0;
    m_count = 4'd0;
    m_per   = 4'd0;
    for (int i = 0; i < 200; i++) begin
      m_count = m_count + 4'd1;
      m_done  = (m_count == 4'd0);
      if (m_done && m_per != 4'd15) m_per = m_per + 4'd1;
      tick();
      checkOutput("gold", m_count, ST_RUN, m_done, m_per, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
